// File: rtl/sddr_wrlvl_engine.sv
// Per-lane DDR3 write-leveling engine: each byte lane searches its DQS IDELAY for
// the first 0->1 transition of the DQ feedback and locks there, or fails at the last tap.
module sddr_wrlvl_engine #(
   parameter int LANES         = 2,
   parameter int MAX_TAPS      = 32,
   parameter int SETTLE_CYCLES = 16,
   parameter int PULSE_LAT     = 6,
   parameter int SAMPLES       = 8
) (
   input  logic                            in_ddr_clock_i,
   input  logic                            in_phy_reset_n_i,
   input  logic                            start_i,
   input  logic [LANES-1:0]                lane_dq_i,
   output logic                            write_level_o,
   output logic                            dqs_pulse_o,
   output logic                            tap_rst_o,
   output logic [LANES-1:0]                delay_inc_o,
   output logic [LANES*$clog2(MAX_TAPS)-1:0] tap_o,
   output logic [LANES-1:0]                lane_lock_o,
   output logic [LANES-1:0]                lane_fail_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            error_o,
   output logic [2:0]                      state_o
);

   localparam int TAP_BITS  = $clog2(MAX_TAPS);
   localparam int ONES_BITS = $clog2(SAMPLES + 1);
   localparam int CNT_MAX   = (SETTLE_CYCLES > PULSE_LAT) ?
                              ((SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES) :
                              ((PULSE_LAT > SAMPLES) ? PULSE_LAT : SAMPLES);
   localparam int CNT_BITS  = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      PULSE  = 3'd2,
      WAIT   = 3'd3,
      SAMPLE = 3'd4,
      EVAL   = 3'd5,
      INC    = 3'd6,
      DONE   = 3'd7
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [CNT_BITS-1:0]   cnt;
   logic                  start_go;
   logic [LANES-1:0]      sync1;
   logic [LANES-1:0]      sync2;
   logic [TAP_BITS-1:0]   tap [LANES];
   logic [ONES_BITS-1:0]  ones [LANES];
   logic [LANES-1:0]      seen_zero;
   logic [LANES-1:0]      lock_nxt;
   logic [LANES-1:0]      fail_nxt;
   logic [LANES-1:0]      seen_zero_nxt;
   logic [LANES-1:0]      inc_mask;
   logic                  all_settled;

   // Per-lane evaluation of the sampled window; only meaningful while in EVAL.
   always_comb begin
      lock_nxt      = lane_lock_o;
      fail_nxt      = lane_fail_o;
      seen_zero_nxt = seen_zero;
      for (int i = 0; i < LANES; i++) begin
         if (!lane_lock_o[i] && !lane_fail_o[i]) begin
            if (ones[i] > ONES_BITS'(SAMPLES / 2)) begin
               if (seen_zero[i]) lock_nxt[i] = 1'b1;
            end else begin
               seen_zero_nxt[i] = 1'b1;
            end
            if (!lock_nxt[i] && (tap[i] == TAP_BITS'(MAX_TAPS - 1))) fail_nxt[i] = 1'b1;
         end
      end
      inc_mask    = ~(lock_nxt | fail_nxt);
      all_settled = &(lock_nxt | fail_nxt);
   end

   always_comb begin
      next_state = state;
      start_go   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_i) begin
               next_state = SETTLE;
               start_go   = 1'b1;
            end
         end
         SETTLE: if (cnt == CNT_BITS'(SETTLE_CYCLES - 1)) next_state = PULSE;
         PULSE:  next_state = WAIT;
         WAIT:   if (cnt == CNT_BITS'(PULSE_LAT - 1)) next_state = SAMPLE;
         SAMPLE: if (cnt == CNT_BITS'(SAMPLES - 1)) next_state = EVAL;
         EVAL:   next_state = all_settled ? DONE : INC;
         INC:    next_state = SETTLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge in_ddr_clock_i or negedge in_phy_reset_n_i) begin
      if (!in_phy_reset_n_i) begin
         state         <= IDLE;
         cnt           <= '0;
         sync1         <= '0;
         sync2         <= '0;
         seen_zero     <= '0;
         lane_lock_o   <= '0;
         lane_fail_o   <= '0;
         write_level_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         dqs_pulse_o   <= 1'b0;
         tap_rst_o     <= 1'b0;
         delay_inc_o   <= '0;
         for (int i = 0; i < LANES; i++) begin
            tap[i]  <= '0;
            ones[i] <= '0;
         end
      end else begin
         state <= next_state;
         sync1 <= lane_dq_i;
         sync2 <= sync1;
         if ((next_state != state) || (state == IDLE) || (state == DONE)) cnt <= '0;
         else cnt <= cnt + 1'b1;

         // All pulse outputs are decoded from next_state, so at most one is ever high.
         tap_rst_o     <= start_go;
         dqs_pulse_o   <= (next_state == PULSE);
         delay_inc_o   <= (next_state == INC) ? inc_mask : '0;
         done_o        <= (next_state == DONE);
         write_level_o <= (next_state != IDLE) && (next_state != DONE);
         busy_o        <= (next_state != IDLE) && (next_state != DONE);

         if (start_go) begin
            seen_zero   <= '0;
            lane_lock_o <= '0;
            lane_fail_o <= '0;
         end else if (state == EVAL) begin
            seen_zero   <= seen_zero_nxt;
            lane_lock_o <= lock_nxt;
            lane_fail_o <= fail_nxt;
         end

         for (int i = 0; i < LANES; i++) begin
            if (start_go) tap[i] <= '0;
            else if ((state == INC) && delay_inc_o[i]) tap[i] <= tap[i] + 1'b1;

            if (state == WAIT) ones[i] <= '0;
            else if ((state == SAMPLE) && !lane_lock_o[i] && !lane_fail_o[i])
               ones[i] <= ones[i] + ONES_BITS'(sync2[i]);
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_tap
      assign tap_o[g*TAP_BITS +: TAP_BITS] = tap[g];
   end

   assign error_o = done_o & (|lane_fail_o);
   assign state_o = state;

endmodule

// File: tb/tb_sddr_wrlvl_engine.sv
// Directed bench for sddr_wrlvl_engine: a tap-driven DQ feedback model per lane,
// pulse/period monitors, and hand-computed expected taps, lock and fail flags.
module tb_sddr_wrlvl_engine;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] lane_dq;
   logic       write_level;
   logic       dqs_pulse;
   logic       tap_rst;
   logic [1:0] delay_inc;
   logic [9:0] tap;
   logic [1:0] lane_lock;
   logic [1:0] lane_fail;
   logic       busy;
   logic       done;
   logic       error;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   sddr_wrlvl_engine dut (
      .in_ddr_clock_i   (clk),
      .in_phy_reset_n_i (rst_n),
      .start_i          (start),
      .lane_dq_i        (lane_dq),
      .write_level_o    (write_level),
      .dqs_pulse_o      (dqs_pulse),
      .tap_rst_o        (tap_rst),
      .delay_inc_o      (delay_inc),
      .tap_o            (tap),
      .lane_lock_o      (lane_lock),
      .lane_fail_o      (lane_fail),
      .busy_o           (busy),
      .done_o           (done),
      .error_o          (error),
      .state_o          (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Feedback modes: 0 = level (tap >= thr), 1 = always 0, 2 = notch, 3 = pulse-relative pattern
   int         mode [2];
   int         thr  [2];
   int         rel = 100;
   logic [7:0] pat  [4];

   always @(negedge clk) begin
      if (dqs_pulse) rel = 0;
      else if (rel < 100) rel = rel + 1;
      for (int i = 0; i < 2; i++) begin
         int t;
         t = int'(tap[i*5 +: 5]);
         case (mode[i])
            0: lane_dq[i] = (t >= thr[i]);
            1: lane_dq[i] = 1'b0;
            2: lane_dq[i] = (t <= 2) || (t >= 9);
            default: begin
               if (rel >= 5 && rel <= 12) lane_dq[i] = pat[(t > 3) ? 3 : t][rel-5];
               else lane_dq[i] = 1'b0;
            end
         endcase
      end
   end

   int cyc = 0;
   int inc_cnt [2];
   int rst_cnt, period_n, period_bad, overlap, last_inc;

   always @(negedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) if (delay_inc[i]) inc_cnt[i] = inc_cnt[i] + 1;
      if (tap_rst) rst_cnt = rst_cnt + 1;
      if ((int'(tap_rst) + int'(dqs_pulse) + int'(|delay_inc)) > 1) overlap = overlap + 1;
      if (|delay_inc) begin
         if (last_inc >= 0) begin
            period_n = period_n + 1;
            if (cyc - last_inc != 33) period_bad = period_bad + 1;
         end
         last_inc = cyc;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk);
      #1;
      inc_cnt[0] = 0;
      inc_cnt[1] = 0;
      rst_cnt    = 0;
      period_n   = 0;
      period_bad = 0;
      overlap    = 0;
      last_inc   = -1;
   endtask

   task automatic set_model(input int m0, input int t0, input int m1, input int t1);
      mode[0] = m0;
      thr[0]  = t0;
      mode[1] = m1;
      thr[1]  = t1;
   endtask

   // Start is sampled at the posedge between the two negedges; tap_rst must be high right after.
   task automatic pulse_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val({tag, "_tap_rst"}, tap_rst, 1);
      check_val({tag, "_busy"}, busy, 1);
      check_val({tag, "_wl"}, write_level, 1);
      check_val({tag, "_done_clr"}, done, 0);
      check_val({tag, "_tap_clr"}, tap, 0);
      check_val({tag, "_lock_clr"}, lane_lock, 0);
      check_val({tag, "_fail_clr"}, lane_fail, 0);
      @(negedge clk);
      check_val({tag, "_tap_rst_1cyc"}, tap_rst, 0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check_val({tag, "_done"}, done, 1);
      check_val({tag, "_busy_off"}, busy, 0);
      check_val({tag, "_wl_off"}, write_level, 0);
      check_val({tag, "_overlap"}, overlap, 0);
      check_val({tag, "_rst_cnt"}, rst_cnt, 1);
   endtask

   task automatic check_result(input string tag, input int t0, input int t1, input int lk,
                               input int fl, input int er, input int n0, input int n1);
      check_val({tag, "_tap0"}, tap[4:0], t0);
      check_val({tag, "_tap1"}, tap[9:5], t1);
      check_val({tag, "_lock"}, lane_lock, lk);
      check_val({tag, "_fail"}, lane_fail, fl);
      check_val({tag, "_error"}, error, er);
      check_val({tag, "_inc0"}, inc_cnt[0], n0);
      check_val({tag, "_inc1"}, inc_cnt[1], n1);
      check_val({tag, "_period_bad"}, period_bad, 0);
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_state"}, state, 0);
      check_val({tag, "_wl"}, write_level, 0);
      check_val({tag, "_pulse"}, dqs_pulse, 0);
      check_val({tag, "_tap_rst"}, tap_rst, 0);
      check_val({tag, "_inc"}, delay_inc, 0);
      check_val({tag, "_tap"}, tap, 0);
      check_val({tag, "_lock"}, lane_lock, 0);
      check_val({tag, "_fail"}, lane_fail, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_error"}, error, 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      lane_dq = 2'b00;
      pat[0]  = 8'b0000_0000;
      pat[1]  = 8'b0101_0101;
      pat[2]  = 8'b1011_0101;
      pat[3]  = 8'b1111_1111;
      set_model(0, 5, 0, 12);

      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // Level feedback, thresholds 5 and 12; a start while busy must change nothing.
      clear_mon();
      pulse_start("t1");
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("t1_busy_start_ignored", tap_rst, 0);
      wait_done("t1", 2000);
      check_result("t1", 5, 12, 3, 0, 0, 5, 12);
      check_val("t1_period_n", period_n, 11);

      // Restart from DONE; lane0 sees 1 at taps 0-2 before the real rising edge at 9.
      set_model(2, 0, 0, 12);
      clear_mon();
      pulse_start("t2");
      wait_done("t2", 2000);
      check_result("t2", 9, 12, 3, 0, 0, 9, 12);

      // Lane1 never sees a 1: it must stop at the last tap and flag failure.
      set_model(0, 5, 1, 0);
      clear_mon();
      pulse_start("t3");
      wait_done("t3", 3000);
      check_result("t3", 5, 31, 1, 2, 1, 5, 31);

      // Majority filter: tap1 gives 4 of 8 ones (a zero), tap2 gives 5 of 8 (a one).
      set_model(3, 0, 0, 3);
      clear_mon();
      pulse_start("t4");
      wait_done("t4", 2000);
      check_result("t4", 2, 3, 3, 0, 0, 2, 3);

      // Asynchronous reset while sampling, then a fresh calibration.
      set_model(0, 5, 0, 12);
      clear_mon();
      pulse_start("t5");
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (state == 3'd4 && tap[4:0] == 5'd2) break;
      end
      check_val("t5_in_sample", state, 4);
      rst_n = 1'b0;
      #1;
      check_idle("t5_async_rst");
      @(negedge clk);
      check_idle("t5_rst_held");
      rst_n = 1'b1;
      @(negedge clk);
      clear_mon();
      pulse_start("t6");
      wait_done("t6", 2000);
      check_result("t6", 5, 12, 3, 0, 0, 5, 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
